// File: rtl/gcd_ip_top.sv
// Subtraction-based Euclid GCD engine: one step per clock, operands captured from
// the pins whenever idle, and the result held until the operands change.
//
// state | meaning
// IDLE  | waiting for a nonzero operand pair, outputs cleared
// CALC  | subtracting the smaller working value from the larger one
// DONE  | result valid on cout, watching a/b for a change
module gcd_ip_top #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] cout,
  output logic             isdone
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] a_cap;
  logic [WIDTH-1:0] b_cap;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      x      <= '0;
      y      <= '0;
      a_cap  <= '0;
      b_cap  <= '0;
      cout   <= '0;
      isdone <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cout   <= '0;
          isdone <= 1'b0;
          if ((a != '0) || (b != '0)) begin
            x     <= a;
            y     <= b;
            a_cap <= a;
            b_cap <= b;
            state <= CALC;
          end
        end
        CALC: begin
          // Larger value is always the minuend, so neither subtraction can wrap.
          if (y == '0) begin
            cout   <= x;
            isdone <= 1'b1;
            state  <= DONE;
          end else if (x == '0) begin
            cout   <= y;
            isdone <= 1'b1;
            state  <= DONE;
          end else if (x == y) begin
            cout   <= x;
            isdone <= 1'b1;
            state  <= DONE;
          end else if (x > y) begin
            x <= x - y;
          end else begin
            y <= y - x;
          end
        end
        DONE: begin
          // New operands are captured only after a pass through IDLE.
          if ((a != a_cap) || (b != b_cap)) begin
            cout   <= '0;
            isdone <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          cout   <= '0;
          isdone <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_ip_top.sv
// Scoreboard bench for gcd_ip_top: stimulus pushes expected results and latencies,
// a negedge monitor pops and compares whenever isdone rises.
module tb_gcd_ip_top;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] a   = '0;
  logic [W-1:0] b   = '0;
  logic [W-1:0] cout;
  logic         isdone;

  gcd_ip_top #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .a     (a),
    .b     (b),
    .cout  (cout),
    .isdone(isdone)
  );

  always #5 clk = ~clk;

  typedef struct {
    int val;
    int lat;
    int start;
    bit chk_lat;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   prev_done = 1'b0;

  always @(posedge clk) cyc = cyc + 1;

  function automatic int ref_gcd(int x, int y);
    while (y != 0) begin
      int t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // capture + one cycle per subtraction + finish
  function automatic int ref_lat(int x, int y);
    int n = 2;
    while (x != 0 && y != 0 && x != y) begin
      if (x > y) x = x - y;
      else y = y - x;
      n++;
    end
    return n;
  endfunction

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!isdone) check("cout_zero_when_not_done", int'(cout), 0);
    if (isdone && !prev_done) begin
      if (sb.size() == 0) begin
        check("unexpected_result", int'(cout), -1);
      end else begin
        mon_e = sb.pop_front();
        check("result", int'(cout), mon_e.val);
        if (mon_e.chk_lat) check("latency", cyc - mon_e.start, mon_e.lat);
      end
    end
    prev_done = isdone;
  end

  task automatic apply_reset(int na, int nb);
    @(negedge clk);
    rst = 1'b0;
    a   = W'(na);
    b   = W'(nb);
    sb.delete();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic issue_reset(int na, int nb);
    apply_reset(na, nb);
    sb.push_back('{ref_gcd(na, nb), ref_lat(na, nb), cyc, 1'b1});
  endtask

  task automatic wait_empty(int bound, string name);
    int n = 0;
    while (sb.size() != 0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    #1;
    check(name, sb.size(), 0);
    sb.delete();
  endtask

  task automatic run_and_hold(int na, int nb, string name);
    issue_reset(na, nb);
    wait_empty(400, name);
    repeat (4) @(negedge clk);
    #1;
    check({name, "_hold_isdone"}, int'(isdone), 1);
    check({name, "_hold_cout"}, int'(cout), ref_gcd(na, nb));
  endtask

  initial begin
    int ra, rb;

    // reset state, asserted from time zero
    #2;
    check("reset_cout", int'(cout), 0);
    check("reset_isdone", int'(isdone), 0);

    run_and_hold(48, 18, "t1_48_18");

    run_and_hold(56, 98, "t2_56_98");
    run_and_hold(60, 45, "t2_60_45");
    run_and_hold(18, 48, "t2_18_48");

    run_and_hold(255, 1, "t3_255_1");
    run_and_hold(200, 200, "t3_200_200");
    run_and_hold(0, 37, "t3_0_37");
    run_and_hold(37, 0, "t3_37_0");

    apply_reset(0, 0);
    repeat (25) begin
      @(negedge clk);
      #1;
      check("t3_zero_isdone", int'(isdone), 0);
      check("t3_zero_cout", int'(cout), 0);
    end

    // operand change while DONE forces a pass through IDLE before recapture
    issue_reset(48, 18);
    wait_empty(400, "t4_first");
    @(negedge clk);
    b = W'(20);
    sb.push_back('{ref_gcd(48, 20), ref_lat(48, 20), cyc + 1, 1'b1});
    @(posedge clk);
    #1;
    check("t4_clear_isdone", int'(isdone), 0);
    check("t4_clear_cout", int'(cout), 0);
    wait_empty(400, "t4_second");

    // asynchronous abort mid-computation
    issue_reset(255, 1);
    repeat (50) @(posedge clk);
    #3;
    rst = 1'b0;
    sb.delete();
    #1;
    check("t5_abort_cout", int'(cout), 0);
    check("t5_abort_isdone", int'(isdone), 0);
    run_and_hold(12, 8, "t5_12_8");

    // a changed mid-CALC: old result first, then the restarted one
    issue_reset(48, 18);
    repeat (3) @(negedge clk);
    a = W'(50);
    sb.push_back('{ref_gcd(50, 18), 0, 0, 1'b0});
    wait_empty(800, "t6_restart");

    for (int i = 0; i < 25; i++) begin
      ra = int'($urandom_range(0, 255));
      rb = int'($urandom_range(0, 255));
      if (ra == 0 && rb == 0) rb = 1;
      issue_reset(ra, rb);
      wait_empty(400, "rand_run");
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
